// File: rtl/counter_pkg.sv
// Shared definitions for the reload counter: FSM state encoding and the
// width helper used to size the prescaler counter.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold 0..value-1; never returns less than 1 so vectors stay legal.
    function automatic int clog2(input int value);
        int width;
        int one;
        width = 1;
        one   = 1;
        for (int i = 1; i < 31; i++) begin
            if ((one << i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/reload_counter_if.sv
// Control and status bundle of the reload counter; the counter is the slave,
// the controlling logic is the master.
interface reload_counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic             latch;
    logic             dec;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             busy;

    modport master (output in, latch, dec, periodic, input count, zero, tc, busy);
    modport slave  (input in, latch, dec, periodic, output count, zero, tc, busy);
endinterface

// File: rtl/tick_prescaler.sv
// Divides the qualified dec stream: tick fires on every PRESCALE-th enabled
// cycle, in the same cycle as that enable.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int          PW      = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] P_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    logic [PW-1:0] cnt_r;
    logic          at_last_s;

    assign at_last_s = (cnt_r == LAST);
    assign tick      = en & ~clear & at_last_s;

    // Qualified-pulse counter; clear wins over en so a reload restarts the division.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= P_ZERO;
        end else if (clear) begin
            cnt_r <= P_ZERO;
        end else if (en) begin
            cnt_r <= at_last_s ? P_ZERO : (cnt_r + P_ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/reload_counter.sv
// Loadable down-counter with optional prescaler, one-shot or auto-reload
// operation and a registered terminal-count pulse.
module reload_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    reload_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_r, state_n;
    logic [WIDTH-1:0] count_r, count_n;
    logic [WIDTH-1:0] reload_r, reload_n;
    logic             tc_r, tc_n;
    logic             qual_dec_s;
    logic             step_s;

    // latch outranks dec, so a dec coinciding with a latch is never counted.
    assign qual_dec_s = (state_r == ST_RUN) & bus.dec & ~bus.latch;

    generate
        if (PRESCALE > 1) begin : g_presc
            tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
                .clock (clock),
                .reset (reset),
                .clear (bus.latch),
                .en    (qual_dec_s),
                .tick  (step_s)
            );
        end else begin : g_nopresc
            assign step_s = qual_dec_s;
        end
    endgenerate

    // State, count, reload and tc registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            reload_r <= CNT_ZERO;
            tc_r     <= 1'b0;
        end else begin
            state_r  <= state_n;
            count_r  <= count_n;
            reload_r <= reload_n;
            tc_r     <= tc_n;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_n  = state_r;
        count_n  = count_r;
        reload_n = reload_r;
        tc_n     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.latch) begin
                    count_n  = bus.in;
                    reload_n = bus.in;
                    state_n  = (bus.in != CNT_ZERO) ? ST_RUN : ST_IDLE;
                end else begin
                    count_n = CNT_ZERO;
                end
            end
            ST_RUN: begin
                if (bus.latch) begin
                    count_n  = bus.in;
                    reload_n = bus.in;
                    state_n  = (bus.in != CNT_ZERO) ? ST_RUN : ST_IDLE;
                end else if (step_s) begin
                    if (count_r > CNT_ONE) begin
                        count_n = count_r - CNT_ONE;
                    end else if (count_r == CNT_ONE) begin
                        tc_n = 1'b1;
                        if (bus.periodic) begin
                            count_n = reload_r;
                        end else begin
                            count_n = CNT_ZERO;
                            state_n = ST_DONE;
                        end
                    end else begin
                        // Zero while running cannot arise; fall back to IDLE rather than wrap.
                        count_n = CNT_ZERO;
                        state_n = ST_IDLE;
                    end
                end else begin
                    count_n = count_r;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                count_n  = CNT_ZERO;
                reload_n = CNT_ZERO;
            end
        endcase
    end

    assign bus.count = count_r;
    assign bus.zero  = (count_r == CNT_ZERO);
    assign bus.tc    = tc_r;
    assign bus.busy  = (state_r == ST_RUN);
endmodule

// File: tb/tb_reload_counter.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3) driven by directed vectors,
// expectations queued per target cycle and checked by an independent monitor.
module tb_reload_counter;
    logic clock;
    logic reset;

    reload_counter_if #(.WIDTH(4)) if1 ();
    reload_counter_if #(.WIDTH(4)) if3 ();

    reload_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    reload_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (if3)
    );

    typedef struct {
        int         cyc;
        int         sel;
        logic [3:0] count;
        logic       tc;
        logic       busy;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle index used to align queued expectations with the monitor.
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops every expectation due this cycle and compares against the selected DUT.
    always @(negedge clock) begin
        exp_t       e;
        logic [3:0] a_count;
        logic       a_zero, a_tc, a_busy, e_zero;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.sel == 1) begin
                a_count = if1.count; a_zero = if1.zero; a_tc = if1.tc; a_busy = if1.busy;
            end else begin
                a_count = if3.count; a_zero = if3.zero; a_tc = if3.tc; a_busy = if3.busy;
            end
            e_zero = (e.count == 4'd0);
            checks++;
            if (e.cyc != cyc || a_count !== e.count || a_zero !== e_zero ||
                a_tc !== e.tc || a_busy !== e.busy) begin
                failures++;
                $display("FAIL %s: cycle %0d (due %0d) got count=%0d zero=%b tc=%b busy=%b, expected count=%0d zero=%b tc=%b busy=%b",
                         e.nm, cyc, e.cyc, a_count, a_zero, a_tc, a_busy, e.count, e_zero, e.tc, e.busy);
            end
        end
    end

    task automatic drive(input int sel, input logic rs, input logic l, input logic [3:0] i,
                         input logic d, input logic p, input logic [3:0] ec, input logic et,
                         input logic eb, input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rs;
        if1.latch    = (sel == 1) ? l : 1'b0;
        if1.dec      = (sel == 1) ? d : 1'b0;
        if3.latch    = (sel == 3) ? l : 1'b0;
        if3.dec      = (sel == 3) ? d : 1'b0;
        if1.in       = i;
        if3.in       = i;
        if1.periodic = p;
        if3.periodic = p;
        e.cyc   = cyc + 1;
        e.sel   = sel;
        e.count = ec;
        e.tc    = et;
        e.busy  = eb;
        e.nm    = nm;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", sb_q.size());
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if1.in = 4'd0; if1.latch = 1'b0; if1.dec = 1'b0; if1.periodic = 1'b0;
        if3.in = 4'd0; if3.latch = 1'b0; if3.dec = 1'b0; if3.periodic = 1'b0;
        //     sel rs    latch in    dec   per    count tc    busy
        drive(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "rst_dut1");
        drive(3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "rst_dut3");
        // one-shot from 3
        drive(1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, "os_latch");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, "os_dec1");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "os_dec2");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, "os_term");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "os_done_dec");
        // auto-reload from 2, then periodic dropped mid-count
        drive(1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, "ar_latch");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, "ar_dec1");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, "ar_dec2");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, "ar_dec3");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, "ar_dec4");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, "ar_dec5");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, "ar_dec6");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "ar_pchg");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, "ar_term");
        // reload = 1: back-to-back tc
        drive(1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, "r1_latch");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, "r1_dec1");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, "r1_dec2");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, "r1_idle");
        // latch with a terminal dec in the same cycle
        drive(1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, "lp_latch_dec");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, "lp_dec1");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "lp_dec2");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, "lp_dec3");
        // reset mid-run at count 2
        drive(1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "rr_reset");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "rr_dec1");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "rr_dec2");
        // latch 0 from run
        drive(1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, "l0_latch4");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "l0_dec");
        drive(1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "l0_latch0");
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "l0_dec_ign");
        // prescale 3, one-shot from 2
        drive(3, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, "p3_latch");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, "p3_dec1");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, "p3_dec2");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "p3_dec3");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "p3_dec4");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "p3_dec5");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, "p3_dec6");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "p3_done");
        // prescale 3: latch clears a partially filled prescaler
        drive(3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, "pc_latch");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "pc_dec1");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "pc_dec2");
        drive(3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "pc_relatch");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "pc_dec3");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "pc_dec4");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, "pc_dec5");
        drive(3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, "pc_hold");

        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
